cache_mem_responder: RTL and testbench

//  Main-memory side of the cache<->memory line-transfer interface. Answers line read
//  (refill) and line write (write-back) requests from the cache controller after a

---
 rtl/cache_mem_pkg.sv | 14 +
 rtl/mem_line_array.sv | 39 +++
 rtl/cache_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache<->memory line-transfer responder.
package cache_mem_pkg;

  localparam int DEF_LINE_W = 512;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line store. Contents survive reset; only the read
// register is cleared so the responder's read-data output starts at zero.
module mem_line_array
  import cache_mem_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only moves on an explicit read, so the last refill is held
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: serves line refills and write-backs after fixed
// latencies, with a one-entry pending read slot for write-back-before-refill.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LINE_W    = DEF_LINE_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int READ_LAT  = 8,
  parameter int WRITE_LAT = 6,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en_mem,
  input  logic [ADDR_W-1:0] raddr_mem,
  input  logic              write_en_mem,
  input  logic [ADDR_W-1:0] waddr_mem,
  input  logic [LINE_W-1:0] wdata_mem,
  output logic [LINE_W-1:0] rdata_mem,
  output logic              ready_mem,
  output logic              busy_mem,
  output logic              err_ovf
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // From IDLE the request cycle itself counts toward the latency; a read
  // promoted out of RESP waits the full READ_LAT after the RESP cycle.
  localparam logic [CNT_W-1:0] WR_FIRST_CNT  = (WRITE_LAT > 1) ? CNT_W'(WRITE_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] RD_FIRST_CNT  = (READ_LAT > 1) ? CNT_W'(READ_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] RD_QUEUED_CNT = CNT_W'(READ_LAT - 1);

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rdEnPrev_q;
  logic              wrEnPrev_q;
  logic [ADDR_W-1:0] curAddr_q;
  logic [LINE_W-1:0] wrData_q;
  logic              curIsWrite_q;
  logic              slotFull_q;
  logic [ADDR_W-1:0] slotAddr_q;
  logic              readyMem_q;
  logic              errOvf_q;

  logic              rdEdge;
  logic              wrEdge;
  logic              arrWe;
  logic              arrRe;
  logic [ADDR_W-1:0] arrAddr;
  logic [LINE_W-1:0] arrRdata;

  assign rdEdge = read_en_mem & ~rdEnPrev_q;
  assign wrEdge = write_en_mem & ~wrEnPrev_q;

  // The store read is issued the cycle before RESP so data lines up with ready
  always_comb begin
    arrWe   = 1'b0;
    arrRe   = 1'b0;
    arrAddr = curAddr_q;
    case (state_q)
      IDLE: begin
        if (!wrEdge && READ_LAT == 1) begin
          if (slotFull_q) begin
            arrRe   = 1'b1;
            arrAddr = slotAddr_q;
          end else if (rdEdge) begin
            arrRe   = 1'b1;
            arrAddr = raddr_mem;
          end
        end
      end
      RD_WAIT: arrRe = (cnt_q == '0);
      RESP:    arrWe = curIsWrite_q;
      default: ;
    endcase
    if (rst) begin
      arrWe = 1'b0;
      arrRe = 1'b0;
    end
  end

  mem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arrWe),
    .re_i    (arrRe),
    .addr_i  (arrAddr),
    .wdata_i (wrData_q),
    .rdata_o (arrRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdEnPrev_q   <= 1'b0;
      wrEnPrev_q   <= 1'b0;
      curAddr_q    <= '0;
      wrData_q     <= '0;
      curIsWrite_q <= 1'b0;
      slotFull_q   <= 1'b0;
      slotAddr_q   <= '0;
      readyMem_q   <= 1'b0;
      errOvf_q     <= 1'b0;
    end else begin
      rdEnPrev_q <= read_en_mem;
      wrEnPrev_q <= write_en_mem;
      readyMem_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wrEdge) begin
            curIsWrite_q <= 1'b1;
            curAddr_q    <= waddr_mem;
            wrData_q     <= wdata_mem;
            cnt_q        <= WR_FIRST_CNT;
            if (WRITE_LAT == 1) begin
              state_q    <= RESP;
              readyMem_q <= 1'b1;
            end else begin
              state_q <= WR_WAIT;
            end
            if (rdEdge) begin
              if (!slotFull_q) begin
                slotFull_q <= 1'b1;
                slotAddr_q <= raddr_mem;
              end else begin
                errOvf_q <= 1'b1;
              end
            end
          end else if (slotFull_q || rdEdge) begin
            curIsWrite_q <= 1'b0;
            curAddr_q    <= slotFull_q ? slotAddr_q : raddr_mem;
            cnt_q        <= RD_FIRST_CNT;
            if (READ_LAT == 1) begin
              state_q    <= RESP;
              readyMem_q <= 1'b1;
            end else begin
              state_q <= RD_WAIT;
            end
            // A drained slot is refilled by a read edge arriving in the same cycle
            if (slotFull_q) begin
              slotFull_q <= rdEdge;
              slotAddr_q <= raddr_mem;
            end
          end
        end
        WR_WAIT, RD_WAIT: begin
          if (rdEdge) begin
            if (!slotFull_q) begin
              slotFull_q <= 1'b1;
              slotAddr_q <= raddr_mem;
            end else begin
              errOvf_q <= 1'b1;
            end
          end
          if (wrEdge) begin
            errOvf_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q    <= RESP;
            readyMem_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (wrEdge) begin
            errOvf_q <= 1'b1;
          end
          if (slotFull_q) begin
            curIsWrite_q <= 1'b0;
            curAddr_q    <= slotAddr_q;
            cnt_q        <= RD_QUEUED_CNT;
            state_q      <= RD_WAIT;
            slotFull_q   <= 1'b0;
            if (rdEdge) begin
              errOvf_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            if (rdEdge) begin
              slotFull_q <= 1'b1;
              slotAddr_q <= raddr_mem;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_mem = arrRdata;
  assign ready_mem = readyMem_q;
  assign busy_mem  = (state_q != IDLE) | slotFull_q;
  assign err_ovf   = errOvf_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a default-latency instance and a
// latency-1 instance share stimulus; ready pulses are logged per instance.
module tb_cache_mem_responder;

  typedef struct {
    int               cyc;
    logic [511:0]     data;
  } logEnt_t;

  typedef struct {
    string        name;
    bit           fast;
    bit           isWrite;
    logic [9:0]   addr;
    logic [511:0] data;
    int           expLat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         readEn = 1'b0;
  logic [9:0]   rAddr = '0;
  logic         writeEn = 1'b0;
  logic [9:0]   wAddr = '0;
  logic [511:0] wData = '0;

  logic [511:0] slowRdata, fastRdata;
  logic         slowReady, fastReady;
  logic         slowBusy, fastBusy;
  logic         slowErr, fastErr;

  int      absCyc = 0;
  int      testsRun = 0;
  int      testsFailed = 0;
  logEnt_t slowLog[$];
  logEnt_t fastLog[$];
  vec_t    vecs[12];

  cache_mem_responder #(
    .LINE_W(512), .DEPTH(1024), .READ_LAT(8), .WRITE_LAT(6)
  ) dut (
    .clk(clk), .rst(rst),
    .read_en_mem(readEn), .raddr_mem(rAddr),
    .write_en_mem(writeEn), .waddr_mem(wAddr), .wdata_mem(wData),
    .rdata_mem(slowRdata), .ready_mem(slowReady), .busy_mem(slowBusy), .err_ovf(slowErr)
  );

  cache_mem_responder #(
    .LINE_W(512), .DEPTH(1024), .READ_LAT(1), .WRITE_LAT(1)
  ) dutFast (
    .clk(clk), .rst(rst),
    .read_en_mem(readEn), .raddr_mem(rAddr),
    .write_en_mem(writeEn), .waddr_mem(wAddr), .wdata_mem(wData),
    .rdata_mem(fastRdata), .ready_mem(fastReady), .busy_mem(fastBusy), .err_ovf(fastErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) absCyc <= absCyc + 1;

  always @(negedge clk) begin
    if (slowReady === 1'b1) slowLog.push_back('{absCyc, slowRdata});
    if (fastReady === 1'b1) fastLog.push_back('{absCyc, fastRdata});
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int countPulses(bit fast, int base, int fromRel, int toRel);
    logEnt_t q[$];
    int n = 0;
    if (fast) q = fastLog;
    else q = slowLog;
    foreach (q[i]) begin
      if (q[i].cyc >= base + fromRel && q[i].cyc <= base + toRel) n++;
    end
    return n;
  endfunction

  function automatic int pulseAt(bit fast, int base, int fromRel, int toRel, output logic [511:0] data);
    logEnt_t q[$];
    int found = -1;
    data = '0;
    if (fast) q = fastLog;
    else q = slowLog;
    foreach (q[i]) begin
      if (found < 0 && q[i].cyc >= base + fromRel && q[i].cyc <= base + toRel) begin
        found = q[i].cyc - base;
        data  = q[i].data;
      end
    end
    return found;
  endfunction

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) nextCycle();
  endtask

  task automatic applyReset();
    nextCycle();
    rst = 1'b1;
    readEn = 1'b0;
    writeEn = 1'b0;
    waitCycles(2);
    rst = 1'b0;
  endtask

  // One isolated transaction: latency, single pulse, data and busy profile
  task automatic applyStimulus(input vec_t v);
    logic [31:0]  busyVec;
    logic [31:0]  expBusy;
    logic [511:0] d;
    int           base;
    int           rel;
    busyVec = '0;
    nextCycle();
    base = absCyc;
    busyVec[0] = v.fast ? fastBusy : slowBusy;
    if (v.isWrite) begin
      writeEn = 1'b1; wAddr = v.addr; wData = v.data;
    end else begin
      readEn = 1'b1; rAddr = v.addr;
    end
    for (int i = 1; i < 20; i++) begin
      nextCycle();
      busyVec[i] = v.fast ? fastBusy : slowBusy;
      if (i == 1) begin
        readEn = 1'b0;
        writeEn = 1'b0;
      end
    end
    expBusy = ((32'd1 << (v.expLat + 1)) - 32'd1) & ~32'd1;
    rel = pulseAt(v.fast, base, 0, 19, d);
    checkOutput({v.name, " latency"}, rel, v.expLat);
    checkOutput({v.name, " pulses"}, countPulses(v.fast, base, 0, 19), 1);
    checkOutput({v.name, " busy"}, busyVec, expBusy);
    if (!v.isWrite) checkOutput({v.name, " rdata"}, d, v.data);
  endtask

  initial begin
    logic [511:0] d;
    int           base;
    vec_t         tail;

    vecs[0]  = '{"wr5",       0, 1, 10'd5,    {64{8'hA5}}, 6};
    vecs[1]  = '{"rd5",       0, 0, 10'd5,    {64{8'hA5}}, 8};
    vecs[2]  = '{"wr7",       0, 1, 10'd7,    {64{8'h77}}, 6};
    vecs[3]  = '{"wr9",       0, 1, 10'd9,    {8{64'h0123_4567_89AB_CDEF}}, 6};
    vecs[4]  = '{"rd9",       0, 0, 10'd9,    {8{64'h0123_4567_89AB_CDEF}}, 8};
    vecs[5]  = '{"rd7",       0, 0, 10'd7,    {64{8'h77}}, 8};
    vecs[6]  = '{"rd5again",  0, 0, 10'd5,    {64{8'hA5}}, 8};
    vecs[7]  = '{"wr1023",    0, 1, 10'd1023, {16{32'hDEAD_BEEF}}, 6};
    vecs[8]  = '{"fastWr1023",1, 1, 10'd1023, {16{32'hCAFE_F00D}}, 1};
    vecs[9]  = '{"fastRd1023",1, 0, 10'd1023, {16{32'hCAFE_F00D}}, 1};
    vecs[10] = '{"fastWr0",   1, 1, 10'd0,    512'h1, 1};
    vecs[11] = '{"fastRd0",   1, 0, 10'd0,    512'h1, 1};

    applyReset();
    nextCycle();
    checkOutput("reset slow flags", {slowReady, slowBusy, slowErr}, 3'b000);
    checkOutput("reset slow rdata", slowRdata, '0);
    checkOutput("reset fast flags", {fastReady, fastBusy, fastErr}, 3'b000);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    checkOutput("table no overflow", slowErr, 1'b0);

    // Write-back and refill of the same line in one cycle
    applyReset();
    nextCycle();
    base = absCyc;
    writeEn = 1'b1; wAddr = 10'd3; wData = {64{8'h11}};
    readEn = 1'b1;  rAddr = 10'd3;
    nextCycle();
    writeEn = 1'b0; readEn = 1'b0;
    waitCycles(24);
    checkOutput("wb write ready", pulseAt(0, base, 0, 25, d), 6);
    checkOutput("wb read ready", pulseAt(0, base, 7, 25, d), 15);
    checkOutput("wb read rdata", d, {64{8'h11}});
    checkOutput("wb pulses", countPulses(0, base, 0, 25), 2);
    checkOutput("wb no overflow", slowErr, 1'b0);

    // Write enable held for two cycles
    applyReset();
    nextCycle();
    base = absCyc;
    writeEn = 1'b1; wAddr = 10'd4; wData = {64{8'h44}};
    waitCycles(2);
    writeEn = 1'b0;
    waitCycles(12);
    checkOutput("held pulses", countPulses(0, base, 0, 14), 1);
    checkOutput("held ready", pulseAt(0, base, 0, 14, d), 6);
    checkOutput("held no overflow", slowErr, 1'b0);

    // Two reads during a write: first queued, second dropped
    applyReset();
    nextCycle();
    base = absCyc;
    writeEn = 1'b1; wAddr = 10'd8; wData = {64{8'h88}};
    nextCycle();
    writeEn = 1'b0;
    nextCycle();
    readEn = 1'b1; rAddr = 10'd5;
    nextCycle();
    checkOutput("ovf err after queued", slowErr, 1'b0);
    readEn = 1'b0;
    nextCycle();
    readEn = 1'b1; rAddr = 10'd9;
    nextCycle();
    checkOutput("ovf err set", slowErr, 1'b1);
    readEn = 1'b0;
    waitCycles(25);
    checkOutput("ovf pulses", countPulses(0, base, 0, 30), 2);
    checkOutput("ovf write ready", pulseAt(0, base, 0, 30, d), 6);
    checkOutput("ovf read ready", pulseAt(0, base, 7, 30, d), 15);
    checkOutput("ovf read rdata", d, {64{8'hA5}});
    checkOutput("ovf err sticky", slowErr, 1'b1);

    // Reset in the middle of a write wait
    applyReset();
    nextCycle();
    base = absCyc;
    writeEn = 1'b1; wAddr = 10'd7; wData = {64{8'hFF}};
    nextCycle();
    writeEn = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("midrst flags", {slowReady, slowBusy, slowErr}, 3'b000);
    checkOutput("midrst rdata", slowRdata, '0);
    rst = 1'b0;
    waitCycles(10);
    checkOutput("midrst no ready", countPulses(0, base, 0, 14), 0);
    tail = '{"midrstRd7", 0, 0, 10'd7, {64{8'h77}}, 8};
    applyStimulus(tail);

    // Latency-1 write with queued read
    applyReset();
    nextCycle();
    base = absCyc;
    writeEn = 1'b1; wAddr = 10'd2; wData = {64{8'h22}};
    readEn = 1'b1;  rAddr = 10'd2;
    nextCycle();
    writeEn = 1'b0; readEn = 1'b0;
    waitCycles(10);
    checkOutput("fast wb write ready", pulseAt(1, base, 0, 10, d), 1);
    checkOutput("fast wb read ready", pulseAt(1, base, 2, 10, d), 3);
    checkOutput("fast wb rdata", d, {64{8'h22}});
    checkOutput("fast wb pulses", countPulses(1, base, 0, 10), 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
